mc_control: RTL
===============

// Module: mc_control
// PURPOSE
//  Multi-cycle MIPS-subset control unit: FSM sequencing FETCH/DECODE/EXEC/MEM/WB with wait-state memory handshake.
//  Replaces per-instruction combinational control; drives shared-ALU multi-cycle datapath (PC, IR, regfile, ALU, one memory port).
//  Supports add addi addu sub subu and or sll lw sw beq bne bgtz slt sltu; adds bounded memory-wait timeout.
// PARAMETERS
//  WAIT_W        4   width of memory wait counter
//  MEM_WAIT_MAX  15  max cycles waiting on mem_ready before bus_err (must be < 2**WAIT_W)
//  ALUCTR_W      3   width of alu_ctr
// PORTS
//  clk         in   1         clock, all state on rising edge
//  reset       in   1         synchronous, active-high
//  inst        in   32        IR contents (op=[31:26], funct=[5:0])
//  zero        in   1         ALU result == 0
//  sign        in   1         ALU result[31]
//  mem_ready   in   1         memory completes current access this cycle
//  mem_req     out  1         memory access request
//  mem_we      out  1         1=write (sw), 0=read
//  iord        out  1         address select: 0=PC, 1=ALUOut
//  ir_we       out  1         load IR from memory data
//  pc_we       out  1         load PC from pc_src mux
//  pc_src      out  2         0=ALU result (PC+4), 1=ALUOut (branch target)
//  reg_we      out  1         regfile write
//  reg_dst     out  1         1=rd, 0=rt
//  mem_to_reg  out  1         1=MDR, 0=ALUOut
//  alu_src_a   out  1         0=PC, 1=A
//  alu_src_b   out  2         0=B, 1=const 4, 2=ext imm16, 3=ext imm16<<2
//  ext_op      out  1         1=sign-extend, 0=zero-extend
//  alu_ctr     out  ALUCTR_W  0 and,1 or,2 add,3 slt,4 addu,5 sll,6 sub,7 sltu
//  bus_err     out  1         one-cycle pulse on memory timeout
//  state       out  4         current state code (debug)
// BEHAVIOUR
//  Reset: state=FETCH next cycle; every output 0 (alu_ctr=0, state=FETCH=0); wait counter 0; any mem_req dropped.
//  Reset mid-operation (incl. waiting on memory) aborts; no pc_we/reg_we/mem_we issued during or the cycle after.
//  FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctr=add. On mem_ready: ir_we=1, pc_we=1, pc_src=0 -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, alu_ctr=add (branch target -> ALUOut). Always -> EXEC.
//  EXEC: R-type: alu_src_a=1, alu_src_b=0, alu_ctr by funct -> ALUWB. addi: src_b=2, ext_op=1, add -> ALUWB.
//    lw/sw: src_b=2, ext_op=1, add -> MEM. beq/bne/bgtz: src_a=1, src_b=0, sub; pc_src=1,
//    pc_we = beq&zero | bne&~zero | bgtz&~zero&~sign -> FETCH.
//  MEM: mem_req=1, iord=1, mem_we=sw. On mem_ready: sw -> FETCH, lw -> MEMWB.
//  MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH. ALUWB: reg_we=1, reg_dst=R-type, mem_to_reg=0 -> FETCH.
//  Latency (no waits): branch 3, R/addi/sw 4, lw 5 cycles. Each mem wait cycle adds 1.
//  mem_req held high and state held until mem_ready; counter increments per waiting cycle, clears on state exit.
//  Timeout: counter==MEM_WAIT_MAX with mem_ready=0 -> bus_err pulse, mem_req drops, -> FETCH; no ir_we/pc_we/reg_we.
//  mem_ready in same cycle as counter==MEM_WAIT_MAX: completes normally, no bus_err.
//  mem_ready outside FETCH/MEM ignored. sll: alu_ctr=5, datapath supplies shamt.
//  Unsupported op/funct: EXEC -> FETCH, no writes (NOP), unless MC_CTRL_TRAP_EN.
// CONFIGURATION
//  MC_CTRL_TRAP_EN defined: adds port illegal (out 1) and state TRAP; unsupported op/funct in EXEC -> TRAP,
//    illegal=1 held, all strobes 0, stays until reset. Undefined: no port, no TRAP state, NOP as above.
// STRUCTURE
//  mc_ctrl_pkg: state encodings (FETCH=0 DECODE=1 EXEC=2 MEM=3 MEMWB=4 ALUWB=5 TRAP=6), opcode/funct constants,
//    ALU_* alu_ctr codes, ALU_SRC_B_* and PC_SRC_* selects.
//  Sub-module mc_ctrl_decode: combinational op/funct -> instruction class + alu_ctr + legal flag; FSM in mc_control.
// TESTING
//  add $3,$1,$2 (op 0, funct 0x20), mem_ready immediate -> 4 cycles; ALUWB reg_we=1 reg_dst=1 alu_ctr=2 in EXEC.
//  lw (op 0x23) with 2 wait cycles in FETCH and MEM -> 9 cycles; MEMWB mem_to_reg=1 reg_we=1.
//  beq zero=1 -> pc_we=1 pc_src=1 in EXEC; bne zero=1 -> pc_we=0; bgtz zero=0 sign=1 -> pc_we=0.
//  mem_ready held 0 in MEM (sw) -> bus_err pulse at wait 15, next state FETCH, mem_we never with mem_ready.
//  reset asserted in MEM of sw -> next cycle state=0, all outputs 0; fetch resumes after deassert.
//  op 0x3F: trap build -> illegal=1 held until reset; non-trap -> back to FETCH, no strobes.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode, funct and select encodings for the multi-cycle control unit.
// The TRAP state exists only when MC_CTRL_TRAP_EN is defined.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEM    = 4'd3,
        MEMWB  = 4'd4,
        ALUWB  = 4'd5
`ifdef MC_CTRL_TRAP_EN
        , TRAP = 4'd6
`endif
    } state_t;

    typedef enum logic [2:0] {CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_BGTZ, CLS_ILL} cls_t;

    localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_SLL = 6'h00, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

    localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SLT = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4, ALU_SLL = 3'd5, ALU_SUB = 3'd6, ALU_SLTU = 3'd7;

    localparam logic [1:0] ALU_SRC_B_B = 2'd0, ALU_SRC_B_4 = 2'd1, ALU_SRC_B_IMM = 2'd2, ALU_SRC_B_IMM_SH = 2'd3;
    localparam logic [1:0] PC_SRC_ALU = 2'd0, PC_SRC_ALUOUT = 2'd1;

    // Raw datapath strobes before reset gating; field order matches the output concatenation in mc_control.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic       bus_err;
    } ctl_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational op/funct decode into instruction class, EXEC-phase alu_ctr and legal flag.
module mc_ctrl_decode import mc_ctrl_pkg::*; #(
    parameter int ALUCTR_W = 3
) (
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    output cls_t                cls,
    output logic [ALUCTR_W-1:0] alu,
    output logic                legal
);
    logic [2:0] fn_alu, a;
    logic       fn_ok;

    // R-type funct to ALU operation; subu shares the sub encoding
    always_comb begin
        fn_alu = ALU_AND;
        fn_ok  = 1'b1;
        case (funct)
            FN_SLL:  fn_alu = ALU_SLL;
            FN_ADD:  fn_alu = ALU_ADD;
            FN_ADDU: fn_alu = ALU_ADDU;
            FN_SUB:  fn_alu = ALU_SUB;
            FN_SUBU: fn_alu = ALU_SUB;
            FN_AND:  fn_alu = ALU_AND;
            FN_OR:   fn_alu = ALU_OR;
            FN_SLT:  fn_alu = ALU_SLT;
            FN_SLTU: fn_alu = ALU_SLTU;
            default: fn_ok  = 1'b0;
        endcase
    end

    // opcode to class; unsupported encodings leave alu at 0 so EXEC drives nothing
    always_comb begin
        cls = CLS_ILL;
        a   = ALU_AND;
        case (op)
            OP_R:    begin cls = fn_ok ? CLS_R : CLS_ILL; a = fn_ok ? fn_alu : ALU_AND; end
            OP_ADDI: begin cls = CLS_ADDI; a = ALU_ADD; end
            OP_LW:   begin cls = CLS_LW;   a = ALU_ADD; end
            OP_SW:   begin cls = CLS_SW;   a = ALU_ADD; end
            OP_BEQ:  begin cls = CLS_BEQ;  a = ALU_SUB; end
            OP_BNE:  begin cls = CLS_BNE;  a = ALU_SUB; end
            OP_BGTZ: begin cls = CLS_BGTZ; a = ALU_SUB; end
            default: ;
        endcase
    end

    assign alu   = ALUCTR_W'(a);
    assign legal = cls != CLS_ILL;
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS-subset control FSM with wait-state memory handshake and bounded timeout.
// Define MC_CTRL_TRAP_EN to add the illegal port and a sticky TRAP state for unsupported instructions.
module mc_control import mc_ctrl_pkg::*; #(
    parameter int WAIT_W       = 4,
    parameter int MEM_WAIT_MAX = 15,
    parameter int ALUCTR_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst,
    input  logic                zero,
    input  logic                sign,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_op,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic                bus_err,
    output logic [3:0]          state
`ifdef MC_CTRL_TRAP_EN
    , output logic              illegal
`endif
);
`ifdef MC_CTRL_TRAP_EN
    localparam state_t ILL_NXT = TRAP;
`else
    localparam state_t ILL_NXT = FETCH;
`endif

    state_t              st, nxt;
    logic [WAIT_W-1:0]   cnt, cnt_nxt;
    logic                rst_q, idle, timeout, legal, is_br, unused_inst;
    cls_t                cls;
    logic [ALUCTR_W-1:0] dec_alu, alu;
    ctl_t                c;

    mc_ctrl_decode #(.ALUCTR_W(ALUCTR_W)) u_dec (
        .op(inst[31:26]), .funct(inst[5:0]), .cls(cls), .alu(dec_alu), .legal(legal)
    );

    // rst_q keeps the cycle after reset silent so an aborted access cannot be followed by a stray write
    assign idle        = reset | rst_q;
    assign timeout     = !mem_ready && cnt == WAIT_W'(MEM_WAIT_MAX);
    assign is_br       = cls inside {CLS_BEQ, CLS_BNE, CLS_BGTZ};
    assign unused_inst = ^inst[25:6];

    // state register, memory wait counter and post-reset quiet flag
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= FETCH;
            cnt   <= '0;
            rst_q <= 1'b1;
        end else begin
            st    <= rst_q ? FETCH : nxt;
            cnt   <= rst_q ? '0 : cnt_nxt;
            rst_q <= 1'b0;
        end
    end

    // next state and raw strobes; the wait counter only advances while a memory access is stalled
    always_comb begin
        c       = '0;
        alu     = '0;
        nxt     = st;
        cnt_nxt = '0;
        case (st)
            FETCH: begin
                c.mem_req   = !timeout;
                c.alu_src_b = ALU_SRC_B_4;
                c.ir_we     = mem_ready;
                c.pc_we     = mem_ready;
                c.pc_src    = PC_SRC_ALU;
                c.bus_err   = timeout;
                alu         = ALUCTR_W'(ALU_ADD);
                nxt         = mem_ready ? DECODE : FETCH;
                cnt_nxt     = (mem_ready || timeout) ? '0 : cnt + 1'b1;
            end
            DECODE: begin
                c.alu_src_b = ALU_SRC_B_IMM_SH;
                c.ext_op    = 1'b1;
                alu         = ALUCTR_W'(ALU_ADD);
                nxt         = EXEC;
            end
            EXEC: begin
                alu         = dec_alu;
                c.alu_src_a = cls == CLS_R || is_br;
                c.alu_src_b = cls inside {CLS_ADDI, CLS_LW, CLS_SW} ? ALU_SRC_B_IMM : ALU_SRC_B_B;
                c.ext_op    = cls inside {CLS_ADDI, CLS_LW, CLS_SW};
                c.pc_src    = is_br ? PC_SRC_ALUOUT : PC_SRC_ALU;
                c.pc_we     = (cls == CLS_BEQ && zero) || (cls == CLS_BNE && !zero) ||
                              (cls == CLS_BGTZ && !zero && !sign);
                nxt         = !legal ? ILL_NXT : cls inside {CLS_LW, CLS_SW} ? MEM :
                              cls inside {CLS_R, CLS_ADDI} ? ALUWB : FETCH;
            end
            MEM: begin
                c.mem_req = !timeout;
                c.mem_we  = cls == CLS_SW && !timeout;
                c.iord    = 1'b1;
                c.bus_err = timeout;
                nxt       = timeout ? FETCH : !mem_ready ? MEM : cls == CLS_SW ? FETCH : MEMWB;
                cnt_nxt   = (mem_ready || timeout) ? '0 : cnt + 1'b1;
            end
            MEMWB: begin
                c.reg_we     = 1'b1;
                c.mem_to_reg = 1'b1;
                nxt          = FETCH;
            end
            ALUWB: begin
                c.reg_we  = 1'b1;
                c.reg_dst = cls == CLS_R;
                nxt       = FETCH;
            end
`ifdef MC_CTRL_TRAP_EN
            TRAP: nxt = TRAP;
`endif
            default: nxt = FETCH;
        endcase
    end

    assign {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, ext_op, bus_err} = idle ? '0 : c;
    assign alu_ctr = idle ? '0 : alu;
    assign state   = st;
`ifdef MC_CTRL_TRAP_EN
    assign illegal = st == TRAP && !idle;
`endif
endmodule
